pac_disp: RTL

PAC_DISP -- requirements
Module: pac_disp

---
 rtl/pac_pkg.sv | 38 +++
 rtl/pac_disp_if.sv | 39 +++
 rtl/sat_cnt.sv | 30 +++
 rtl/pac_disp.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/pac_pkg.sv
// Shared definitions for the packet dispatcher: beat codes, action fields, cast codes
// and FSM state encoding.
package pac_pkg;

  localparam int unsigned DataW    = 134;
  localparam int unsigned NumPorts = 6;
  localparam int unsigned ActW     = 11;

  localparam int unsigned BeatHi = 133;
  localparam int unsigned BeatLo = 132;

  localparam logic [1:0] BeatHead    = 2'b01;
  localparam logic [1:0] BeatBody    = 2'b11;
  localparam logic [1:0] BeatBodyAlt = 2'b00;
  localparam logic [1:0] BeatTail    = 2'b10;

  localparam int unsigned ActCastHi = 10;
  localparam int unsigned ActCastLo = 9;
  localparam int unsigned ActTypeHi = 8;
  localparam int unsigned ActTypeLo = 6;
  localparam int unsigned ActMapHi  = 5;
  localparam int unsigned ActMapLo  = 0;

  localparam logic [1:0] CastUni   = 2'b00;
  localparam logic [1:0] CastBcast = 2'b10;
  localparam logic [1:0] CastMcast = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFwd  = 2'd1,
    StDrop = 2'd2
  } state_e;

  function automatic logic is_group_cast(input logic [1:0] cast);
    return (cast == CastBcast) || (cast == CastMcast);
  endfunction

endpackage

// File: rtl/pac_disp_if.sv
// Dispatcher bus: inbound beats/action/back-pressure and outbound beats/metadata/counters.
interface pac_disp_if;
  import pac_pkg::*;

  logic [DataW-1:0]    in_pac_data;
  logic                in_pac_data_wr;
  logic                in_pac_valid;
  logic                in_pac_valid_wr;
  logic [ActW-1:0]     in_pac_action;
  logic                in_pac_action_wr;
  logic [NumPorts-1:0] in_port_alf;

  logic [DataW-1:0]    out_pac_data;
  logic                out_pac_data_wr;
  logic                out_pac_valid;
  logic                out_pac_valid_wr;
  logic [NumPorts-1:0] out_pac_bitmap;
  logic [2:0]          out_pac_pkttype;
  logic                out_pac_mcast;
  logic [31:0]         out_pac_fwd_cnt;
  logic [31:0]         out_pac_drop_cnt;
  logic [15:0]         out_pac_err_cnt;

  modport master (
    output in_pac_data, in_pac_data_wr, in_pac_valid, in_pac_valid_wr,
           in_pac_action, in_pac_action_wr, in_port_alf,
    input  out_pac_data, out_pac_data_wr, out_pac_valid, out_pac_valid_wr,
           out_pac_bitmap, out_pac_pkttype, out_pac_mcast,
           out_pac_fwd_cnt, out_pac_drop_cnt, out_pac_err_cnt
  );

  modport slave (
    input  in_pac_data, in_pac_data_wr, in_pac_valid, in_pac_valid_wr,
           in_pac_action, in_pac_action_wr, in_port_alf,
    output out_pac_data, out_pac_data_wr, out_pac_valid, out_pac_valid_wr,
           out_pac_bitmap, out_pac_pkttype, out_pac_mcast,
           out_pac_fwd_cnt, out_pac_drop_cnt, out_pac_err_cnt
  );
endinterface

// File: rtl/sat_cnt.sv
// Saturating up-counter: increments on inc_i, sticks at all-ones.
module sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pac_disp.sv
// Packet dispatcher: filters packets by action bitmap and port back-pressure, forwards
// accepted beats with one cycle of latency and keeps forward/drop/error counts.
module pac_disp
  import pac_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  pac_disp_if.slave bus
);

  state_e              state_q, state_d;
  logic [DataW-1:0]    data_q, data_d;
  logic                data_wr_q, data_wr_d;
  logic                valid_q, valid_d;
  logic                valid_wr_q, valid_wr_d;
  logic [NumPorts-1:0] bitmap_q, bitmap_d;
  logic [2:0]          pkttype_q, pkttype_d;
  logic                mcast_q, mcast_d;
  logic                fwd_inc, drop_inc, err_inc;

  logic [1:0]          beat;
  logic [NumPorts-1:0] eff_map;

  assign beat    = bus.in_pac_data[BeatHi:BeatLo];
  assign eff_map = bus.in_pac_action[ActMapHi:ActMapLo] & ~bus.in_port_alf;

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    data_wr_d  = 1'b0;
    valid_d    = valid_q;
    valid_wr_d = 1'b0;
    bitmap_d   = bitmap_q;
    pkttype_d  = pkttype_q;
    mcast_d    = mcast_q;
    fwd_inc    = 1'b0;
    drop_inc   = 1'b0;
    err_inc    = 1'b0;

    if (bus.in_pac_data_wr) begin
      unique case (state_q)
        StIdle: begin
          if (beat == BeatHead) begin
            if (bus.in_pac_action_wr && (eff_map != '0)) begin
              data_d    = bus.in_pac_data;
              data_wr_d = 1'b1;
              bitmap_d  = eff_map;
              pkttype_d = bus.in_pac_action[ActTypeHi:ActTypeLo];
              mcast_d   = is_group_cast(bus.in_pac_action[ActCastHi:ActCastLo]);
              state_d   = StFwd;
            end else begin
              state_d = StDrop;
            end
          end else if (beat == BeatTail) begin
            err_inc = 1'b1;
          end
        end
        StFwd: begin
          case (beat)
            BeatHead: begin
              // Missing tail: emit an abort marker and swallow the new packet.
              valid_d    = 1'b0;
              valid_wr_d = 1'b1;
              err_inc    = 1'b1;
              drop_inc   = 1'b1;
              state_d    = StDrop;
            end
            BeatTail: begin
              data_d     = bus.in_pac_data;
              data_wr_d  = 1'b1;
              valid_d    = bus.in_pac_valid_wr ? bus.in_pac_valid : 1'b1;
              valid_wr_d = 1'b1;
              fwd_inc    = 1'b1;
              state_d    = StIdle;
            end
            default: begin
              data_d    = bus.in_pac_data;
              data_wr_d = 1'b1;
            end
          endcase
        end
        StDrop: begin
          if (beat == BeatTail) begin
            drop_inc = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      data_q     <= '0;
      data_wr_q  <= 1'b0;
      valid_q    <= 1'b0;
      valid_wr_q <= 1'b0;
      bitmap_q   <= '0;
      pkttype_q  <= '0;
      mcast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      data_wr_q  <= data_wr_d;
      valid_q    <= valid_d;
      valid_wr_q <= valid_wr_d;
      bitmap_q   <= bitmap_d;
      pkttype_q  <= pkttype_d;
      mcast_q    <= mcast_d;
    end
  end

  sat_cnt #(.Width(32)) u_fwd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (fwd_inc),
    .cnt_o (bus.out_pac_fwd_cnt)
  );

  sat_cnt #(.Width(32)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (drop_inc),
    .cnt_o (bus.out_pac_drop_cnt)
  );

  sat_cnt #(.Width(16)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (err_inc),
    .cnt_o (bus.out_pac_err_cnt)
  );

  assign bus.out_pac_data     = data_q;
  assign bus.out_pac_data_wr  = data_wr_q;
  assign bus.out_pac_valid    = valid_q;
  assign bus.out_pac_valid_wr = valid_wr_q;
  assign bus.out_pac_bitmap   = bitmap_q;
  assign bus.out_pac_pkttype  = pkttype_q;
  assign bus.out_pac_mcast    = mcast_q;

endmodule
